// File: rtl/alu_1bit_chain_if.sv
// Operand/result bus for alu_1bit_chain.
//   master : drives in_valid, A, B, cntrl; observes out_valid, result and NZVC flags.
//   slave  : the ALU side of the same bus.
interface alu_1bit_chain_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output in_valid, A, B, cntrl,
        input  out_valid, result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  in_valid, A, B, cntrl,
        output out_valid, result, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/alu_1bit_chain.sv
// Registered WIDTH-bit ALU built as a ripple chain of 1-bit slices plus a
// zero detector. Ops: pass-B, add, subtract, AND, OR, XOR; NZVC flags.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_1bit_chain_if.slave (in_valid/A/B/cntrl in, out_valid/result/flags out)
// Optional feature macro ALU_FLAG_HOLD_EN: when defined, result and flag
// registers load only on in_valid=1; otherwise they load every cycle.
module alu_1bit_chain #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_1bit_chain_if.slave      bus
);
    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    logic [WIDTH-1:0] result_d, result_q;
    logic [WIDTH-1:0] cout_v;
    logic             carry;
    logic             a_bit, b_bit, b_eff, sum_bit;
    logic             is_arith;
    logic             negative_d, negative_q;
    logic             zero_d, zero_q;
    logic             overflow_d, overflow_q;
    logic             carry_out_d, carry_out_q;
    logic             out_valid_d, out_valid_q;
    logic             load;

    // Ripple chain of 1-bit slices; carry into slice 0 is cntrl[0] (the +1 of subtract).
    always_comb begin
        result_d = '0;
        cout_v   = '0;
        a_bit    = 1'b0;
        b_bit    = 1'b0;
        b_eff    = 1'b0;
        sum_bit  = 1'b0;
        carry    = bus.cntrl[0];
        for (int unsigned i = 0; i < WIDTH; i++) begin
            a_bit     = bus.A[i];
            b_bit     = bus.B[i];
            b_eff     = b_bit ^ bus.cntrl[0];
            sum_bit   = a_bit ^ b_eff ^ carry;
            cout_v[i] = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
            case (bus.cntrl)
                OP_PASS_B:      result_d[i] = b_bit;
                OP_ADD, OP_SUB: result_d[i] = sum_bit;
                OP_AND:         result_d[i] = a_bit & b_bit;
                OP_OR:          result_d[i] = a_bit | b_bit;
                OP_XOR:         result_d[i] = a_bit ^ b_bit;
                default:        result_d[i] = 1'b0;
            endcase
            carry = cout_v[i];
        end
    end

    // Flags: C and V only meaningful for add/sub; N and Z for every op.
    always_comb begin
        is_arith    = (bus.cntrl[2:1] == 2'b01);
        carry_out_d = is_arith & cout_v[WIDTH-1];
        overflow_d  = is_arith & (cout_v[WIDTH-1] ^ cout_v[WIDTH-2]);
        negative_d  = result_d[WIDTH-1];
        zero_d      = ~|result_d;
        out_valid_d = bus.in_valid;
    end

    // Load enable for result/flag registers.
    always_comb begin
`ifdef ALU_FLAG_HOLD_EN
        load = bus.in_valid;
`else
        load = 1'b1;
`endif
    end

    // Output register; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                result_q    <= result_d;
                negative_q  <= negative_d;
                zero_q      <= zero_d;
                overflow_q  <= overflow_d;
                carry_out_q <= carry_out_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.negative  = negative_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_alu_1bit_chain.sv
// Self-checking bench for alu_1bit_chain at WIDTH=64: directed vectors
// followed by randomized operations with occasional mid-stream reset,
// compared against an arithmetic reference model.
module tb_alu_1bit_chain;
    localparam int unsigned W = 64;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [W-1:0] exp_result;
    logic         exp_valid, exp_n, exp_z, exp_v, exp_c;

    alu_1bit_chain_if #(.WIDTH(W)) bus ();

    alu_1bit_chain #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on whole words.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         output logic [W-1:0] r, output logic v, output logic c);
        logic [W:0] wide;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: r = b;
            3'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[W-1:0];
                c    = wide[W];
                v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd3: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = '0;
        endcase
    endtask

    task automatic step(input string tag, input logic vin, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op, input logic rst);
        logic [W-1:0] r;
        logic         v, c;
        bus.in_valid = vin;
        bus.A        = a;
        bus.B        = b;
        bus.cntrl    = op;
        reset        = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_valid  = 1'b0;
            exp_result = '0;
            exp_n      = 1'b0;
            exp_z      = 1'b0;
            exp_v      = 1'b0;
            exp_c      = 1'b0;
        end else begin
            exp_valid = vin;
`ifdef ALU_FLAG_HOLD_EN
            if (vin) begin
`else
            begin
`endif
                model(a, b, op, r, v, c);
                exp_result = r;
                exp_n      = r[W-1];
                exp_z      = (r == '0);
                exp_v      = v;
                exp_c      = c;
            end
        end
        check({tag, ".valid"},    W'(bus.out_valid), W'(exp_valid));
        check({tag, ".result"},   bus.result,        exp_result);
        check({tag, ".negative"}, W'(bus.negative),  W'(exp_n));
        check({tag, ".zero"},     W'(bus.zero),      W'(exp_z));
        check({tag, ".overflow"}, W'(bus.overflow),  W'(exp_v));
        check({tag, ".carry"},    W'(bus.carry_out), W'(exp_c));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] corners [6];
        checks = 0;
        errors = 0;
        exp_result = '0;
        {exp_valid, exp_n, exp_z, exp_v, exp_c} = '0;
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        corners[3] = 64'h8000_0000_0000_0000;
        corners[4] = 64'd1;
        corners[5] = 64'd5;

        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.cntrl    = 3'b000;
        reset        = 1'b1;

        step("reset0", 1'b1, 64'd5, 64'd3, 3'b010, 1'b1);
        step("reset1", 1'b0, 64'd0, 64'd0, 3'b000, 1'b1);

        step("add_5_3",     1'b1, 64'd5, 64'd3, 3'b010, 1'b0);
        step("sub_3_5",     1'b1, 64'd3, 64'd5, 3'b011, 1'b0);
        step("sub_5_5",     1'b1, 64'd5, 64'd5, 3'b011, 1'b0);
        step("add_ovf",     1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b0);
        step("add_wrap",    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b0);
        step("and",         1'b1, 64'hF0F0, 64'hFF00, 3'b100, 1'b0);
        step("or",          1'b1, 64'hF0F0, 64'hFF00, 3'b101, 1'b0);
        step("xor",         1'b1, 64'hF0F0, 64'hFF00, 3'b110, 1'b0);
        step("passb",       1'b1, 64'hF0F0, 64'hFF00, 3'b000, 1'b0);
        step("passb_zero",  1'b1, 64'd0, 64'd0, 3'b000, 1'b0);
        step("unused_001",  1'b1, '1, '1, 3'b001, 1'b0);
        step("unused_111",  1'b1, '1, '1, 3'b111, 1'b0);
        step("sub_ovf",     1'b1, 64'h8000_0000_0000_0000, 64'd1, 3'b011, 1'b0);

        // Mid-stream reset: add in flight, then reset, then idle.
        step("mid_add",     1'b1, 64'd40, 64'd2, 3'b010, 1'b0);
        step("mid_rst",     1'b1, 64'd7, 64'd9, 3'b010, 1'b1);
        step("post_idle0",  1'b0, 64'd7, 64'd9, 3'b010, 1'b0);
        step("post_idle1",  1'b0, 64'd1, 64'd1, 3'b011, 1'b0);
        step("post_valid",  1'b1, 64'd1, 64'd1, 3'b010, 1'b0);
        step("idle_hold",   1'b0, 64'hFFFF, 64'h1, 3'b100, 1'b0);

        for (int n = 0; n < 400; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rb = ra;
            step("rand", ($urandom_range(0, 3) != 0), ra, rb, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
